// File: rtl/kgp_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_fetch_pkg
// Description : Shared FSM encoding and defaults for the KGP_RISC fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : One-entry instruction register presented to the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import kgp_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] din,
    input  logic [ADDR_W-1:0]  din_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_valid;

    // Data/address keep their last captured value after the valid bit clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (load) begin
            r_instr    <= din;
            r_instr_pc <= din_pc;
            r_valid    <= 1'b1;
        end else if (clear) begin
            r_valid    <= 1'b0;
        end
    end

    assign instr    = r_instr;
    assign instr_pc = r_instr_pc;
    assign valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch PC owner and instruction-memory front end with redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  pc_next,
    input  logic               redirect,
    input  logic               halt
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(PC_STEP);

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_target, w_target_next;
    logic              w_load, w_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= FETCH;
            r_pc     <= C_RESET_PC;
            r_target <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        w_pc_next = pc_next;
                    end else begin
                        // Request already on the bus; must wait it out.
                        w_target_next = pc_next;
                        w_state_next  = DRAIN;
                    end
                end else if (imem_ready) begin
                    w_load       = 1'b1;
                    w_pc_next    = r_pc + C_PC_STEP;
                    w_state_next = HOLD;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    w_pc_next    = redirect ? pc_next : r_target;
                    w_state_next = FETCH;
                end else if (redirect) begin
                    w_target_next = pc_next;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_clear      = 1'b1;
                    w_pc_next    = pc_next;
                    w_state_next = FETCH;
                end else if (dec_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (redirect) begin
                    w_pc_next    = pc_next;
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W)
    ) u_fetch_buffer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .clear    (w_clear),
        .din      (imem_rdata),
        .din_pc   (r_pc),
        .instr    (instr),
        .instr_pc (instr_pc),
        .valid    (instr_valid)
    );

    // Gate with reset so no request is seen while reset is held.
    assign imem_req  = reset & ((r_state == FETCH) | (r_state == DRAIN));
    assign imem_addr = r_pc;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic        halt;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .pc          (pc),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for checks and drives.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        imem_ready = 1'b0;
        dec_ready  = 1'b0;
        pc_next    = '0;
        redirect   = 1'b0;
        halt       = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // Streaming: one instruction every two cycles
        imem_ready = 1'b1;
        dec_ready  = 1'b1;
        reset      = 1'b1;
        #1;
        chk("s_req0", {31'd0, imem_req}, 32'd1);
        chk("s_addr0", imem_addr, 32'h0);
        tick();
        chk("s_valid0", {31'd0, instr_valid}, 32'd1);
        chk("s_instr0", instr, 32'hA5A5_0000);
        chk("s_ipc0", instr_pc, 32'h0);
        chk("s_req_hold", {31'd0, imem_req}, 32'd0);
        tick();
        chk("s_valid_gap", {31'd0, instr_valid}, 32'd0);
        chk("s_addr4", imem_addr, 32'h4);
        tick();
        chk("s_instr4", instr, 32'hA5A5_0004);
        chk("s_ipc4", instr_pc, 32'h4);
        tick();
        chk("s_addr8", imem_addr, 32'h8);
        tick();
        chk("s_instr8", instr, 32'hA5A5_0008);
        chk("s_ipc8", instr_pc, 32'h8);

        // Halt on consume of PC 8
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        redirect = 1'b1;
        pc_next  = 32'h10;
        tick();
        redirect = 1'b0;
        chk("halt_redir_req", {31'd0, imem_req}, 32'd1);
        chk("halt_redir_addr", imem_addr, 32'h10);

        // Decoder stall after first capture
        reset     = 1'b0;
        #1;
        reset     = 1'b1;
        dec_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", instr, 32'hA5A5_0000);
            chk("stall_ipc", instr_pc, 32'h0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", pc, 32'h4);
        end
        dec_ready = 1'b1;
        tick();
        chk("stall_consume_addr", imem_addr, 32'h4);
        chk("stall_consume_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect in HOLD beats dec_ready
        tick();
        chk("hold_ipc4", instr_pc, 32'h4);
        redirect = 1'b1;
        pc_next  = 32'h40;
        tick();
        redirect = 1'b0;
        chk("hredir_valid", {31'd0, instr_valid}, 32'd0);
        chk("hredir_addr", imem_addr, 32'h40);
        chk("hredir_ipc_kept", instr_pc, 32'h4);
        chk("hredir_instr_kept", instr, 32'hA5A5_0004);

        // Redirect in FETCH while memory stalls -> DRAIN
        imem_ready = 1'b0;
        redirect   = 1'b1;
        pc_next    = 32'h80;
        tick();
        redirect   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_addr", imem_addr, 32'h40);
            chk("drain_req", {31'd0, imem_req}, 32'd1);
            chk("drain_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        tick();
        chk("drain_done_valid", {31'd0, instr_valid}, 32'd0);
        chk("drain_done_addr", imem_addr, 32'h80);

        // Latest redirect in DRAIN wins
        imem_ready = 1'b0;
        redirect   = 1'b1;
        pc_next    = 32'h100;
        tick();
        pc_next    = 32'h200;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("drain_latest_addr", imem_addr, 32'h200);

        // Redirect coincident with ready in DRAIN goes straight to pc_next
        imem_ready = 1'b0;
        redirect   = 1'b1;
        pc_next    = 32'h300;
        tick();
        pc_next    = 32'h400;
        imem_ready = 1'b1;
        tick();
        chk("drain_same_cycle_addr", imem_addr, 32'h400);
        chk("drain_same_cycle_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect with ready in FETCH discards data
        pc_next = 32'h500;
        tick();
        redirect = 1'b0;
        chk("fetch_redir_addr", imem_addr, 32'h500);
        chk("fetch_redir_valid", {31'd0, instr_valid}, 32'd0);

        // PC wrap-around
        tick();
        redirect = 1'b1;
        pc_next  = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        dec_ready = 1'b0;
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'h5A5A_FFFC);
        dec_ready = 1'b1;
        tick();

        // Reset mid-DRAIN
        imem_ready = 1'b0;
        redirect   = 1'b1;
        pc_next    = 32'h600;
        tick();
        redirect   = 1'b0;
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("post_rst_no_valid", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        dec_ready  = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);
        chk("post_rst_ipc", instr_pc, 32'h0);
        chk("post_rst_instr", instr, 32'hA5A5_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
